vbs_sad_best_mv: RTL and testbench

- Sequential successor to the 41-partition variable-block-size SAD stage.
- Consumes one full set of 41 partition SADs per search candidate, which are full-width and no longer truncated to pixel width.
- Tracks, per partition, the minimum SAD and the motion vector that produced it, across a parametrised search window.
- Sits between the SAD tree and mode decision, and reports results through a start/busy/done handshake.

---
 rtl/vbs_pkg.sv | 23 ++
 rtl/vbs_sad_best_mv_if.sv | 30 +++
 rtl/vbs_sad_best_mv_sad_min_cell.sv | 45 ++++
 rtl/vbs_sad_best_mv.sv | 117 +++++++++++
 tb/tb_vbs_sad_best_mv.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/vbs_pkg.sv
// Shared definitions for the variable-block-size best-MV search stage:
// partition count, partition index map and the controller state type.
package vbs_pkg;

  // Number of partitions produced per candidate by the SAD tree.
  localparam int NPART = 41;

  // First index of each partition class in the packed SAD vector.
  localparam int P4X4_BASE   = 0;
  localparam int P4X8_BASE   = 16;
  localparam int P8X4_BASE   = 24;
  localparam int P8X8_BASE   = 32;
  localparam int P16X8_BASE  = 36;
  localparam int P8X16_BASE  = 38;
  localparam int P16X16      = 40;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/vbs_sad_best_mv_if.sv
// Handshake and data bundle between the SAD tree / mode decision (master)
// and the best-MV search stage (slave).
interface vbs_sad_best_mv_if
  import vbs_pkg::*;
#(
  parameter int SAD_WIDTH = 16,
  parameter int MV_WIDTH  = 8
) ();

  logic                        start;
  logic                        abort;
  logic                        sad_valid;
  logic [NPART*SAD_WIDTH-1:0]  sad_in;
  logic                        busy;
  logic                        done;
  logic [NPART*SAD_WIDTH-1:0]  best_sad;
  logic [NPART*MV_WIDTH-1:0]   best_mvx;
  logic [NPART*MV_WIDTH-1:0]   best_mvy;

  modport master (
    output start, abort, sad_valid, sad_in,
    input  busy, done, best_sad, best_mvx, best_mvy
  );

  modport slave (
    input  start, abort, sad_valid, sad_in,
    output busy, done, best_sad, best_mvx, best_mvy
  );

endinterface

// File: rtl/vbs_sad_best_mv_sad_min_cell.sv
// One partition's running minimum: keeps the smallest SAD seen so far and
// the motion vector that produced it. Strict compare keeps the first of
// equal SADs in candidate order.
module sad_min_cell #(
  parameter int SAD_WIDTH = 16,
  parameter int MV_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [SAD_WIDTH-1:0] sad_in,
  input  logic [MV_WIDTH-1:0]  mvx_in,
  input  logic [MV_WIDTH-1:0]  mvy_in,
  output logic [SAD_WIDTH-1:0] sad,
  output logic [MV_WIDTH-1:0]  mvx,
  output logic [MV_WIDTH-1:0]  mvy
);

  logic [SAD_WIDTH-1:0] sad_reg;
  logic [MV_WIDTH-1:0]  mvx_reg;
  logic [MV_WIDTH-1:0]  mvy_reg;

  // Clear to "no candidate yet" on a new search, else take a strictly smaller SAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sad_reg <= '1;
      mvx_reg <= '0;
      mvy_reg <= '0;
    end else if (clr) begin
      sad_reg <= '1;
      mvx_reg <= '0;
      mvy_reg <= '0;
    end else if (en && (sad_in < sad_reg)) begin
      sad_reg <= sad_in;
      mvx_reg <= mvx_in;
      mvy_reg <= mvy_in;
    end
  end

  assign sad = sad_reg;
  assign mvx = mvx_reg;
  assign mvy = mvy_reg;

endmodule

// File: rtl/vbs_sad_best_mv.sv
// Per-partition best motion vector search. Walks the search window in raster
// order (mvy outer, mvx inner), one candidate per accepted sad_valid, and
// keeps the minimum SAD and its MV for each of the 41 partitions.
module vbs_sad_best_mv
  import vbs_pkg::*;
#(
  parameter int SAD_WIDTH = 16,
  parameter int SRCH_X    = 8,
  parameter int SRCH_Y    = 8,
  parameter int MV_WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  vbs_sad_best_mv_if.slave  bus
);

  localparam logic signed [MV_WIDTH-1:0] MVX_MAX = MV_WIDTH'(SRCH_X);
  localparam logic signed [MV_WIDTH-1:0] MVY_MAX = MV_WIDTH'(SRCH_Y);
  localparam logic signed [MV_WIDTH-1:0] MVX_MIN = -MVX_MAX;
  localparam logic signed [MV_WIDTH-1:0] MVY_MIN = -MVY_MAX;
  localparam logic signed [MV_WIDTH-1:0] MV_ONE  = MV_WIDTH'(1);

  state_t state_reg;
  state_t state_next;

  logic signed [MV_WIDTH-1:0] mvx_cnt;
  logic signed [MV_WIDTH-1:0] mvy_cnt;

  logic clr;
  logic accept;
  logic last_cand;

  // A start is only taken when idle or finishing; abort always wins.
  assign clr       = bus.start && !bus.abort &&
                     ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign accept    = (state_reg == ST_SEARCH) && !bus.abort && bus.sad_valid;
  assign last_cand = (mvx_cnt == MVX_MAX) && (mvy_cnt == MVY_MAX);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic for the start/search/done sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (clr) state_next = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (bus.abort)                  state_next = ST_IDLE;
        else if (accept && last_cand)   state_next = ST_DONE;
      end
      ST_DONE: begin
        if (clr) state_next = ST_SEARCH;
        else     state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Raster position of the candidate currently on sad_in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mvx_cnt <= '0;
      mvy_cnt <= '0;
    end else if (clr) begin
      mvx_cnt <= MVX_MIN;
      mvy_cnt <= MVY_MIN;
    end else if (accept) begin
      if (mvx_cnt == MVX_MAX) begin
        mvx_cnt <= MVX_MIN;
        mvy_cnt <= (mvy_cnt == MVY_MAX) ? MVY_MIN : (mvy_cnt + MV_ONE);
      end else begin
        mvx_cnt <= mvx_cnt + MV_ONE;
      end
    end
  end

  assign bus.busy = (state_reg == ST_SEARCH);
  assign bus.done = (state_reg == ST_DONE);

  logic [SAD_WIDTH-1:0] sad_arr [NPART];
  logic [MV_WIDTH-1:0]  mvx_arr [NPART];
  logic [MV_WIDTH-1:0]  mvy_arr [NPART];

  genvar gi;
  generate
    for (gi = 0; gi < NPART; gi++) begin : g_cell
      sad_min_cell #(
        .SAD_WIDTH (SAD_WIDTH),
        .MV_WIDTH  (MV_WIDTH)
      ) u_cell (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (accept),
        .sad_in (bus.sad_in[gi*SAD_WIDTH +: SAD_WIDTH]),
        .mvx_in (mvx_cnt),
        .mvy_in (mvy_cnt),
        .sad    (sad_arr[gi]),
        .mvx    (mvx_arr[gi]),
        .mvy    (mvy_arr[gi])
      );

      assign bus.best_sad[gi*SAD_WIDTH +: SAD_WIDTH] = sad_arr[gi];
      assign bus.best_mvx[gi*MV_WIDTH +: MV_WIDTH]   = mvx_arr[gi];
      assign bus.best_mvy[gi*MV_WIDTH +: MV_WIDTH]   = mvy_arr[gi];
    end
  endgenerate

endmodule

// File: tb/tb_vbs_sad_best_mv.sv
// Directed bench for vbs_sad_best_mv with a 5x5 search window (25 candidates).
module tb_vbs_sad_best_mv;

  localparam int SW = 16;
  localparam int MW = 8;
  localparam int NP = 41;
  localparam int NC = 25;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  vbs_sad_best_mv_if #(.SAD_WIDTH(SW), .MV_WIDTH(MW)) bus ();

  vbs_sad_best_mv #(
    .SAD_WIDTH (SW),
    .SRCH_X    (2),
    .SRCH_Y    (2),
    .MV_WIDTH  (MW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [NP*SW-1:0] obs, input logic [NP*SW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus SAD for test t, candidate c, partition p.
  function automatic logic [SW-1:0] sad_val(input int t, input int c, input int p);
    case (t)
      2: return (c == 12) ? SW'(5) : SW'(1000);
      3: begin
        if (p == 0 && c == 0)   return SW'(3);
        if (p == 40 && c == 24) return SW'(7);
        return SW'(500);
      end
      4: begin
        if (p == 36 && (c == 4 || c == 20)) return SW'(50);
        if (p == 5) return SW'(900 - c);
        return SW'(900);
      end
      5: return (p % 2 == 0) ? SW'(200 - 3 * c) : SW'(100 + c);
      6: return SW'(300 - c);
      default: return SW'(1000);
    endcase
  endfunction

  task automatic drive(input int t, input int c);
    for (int p = 0; p < NP; p++) bus.sad_in[p*SW +: SW] = sad_val(t, c, p);
  endtask

  task automatic chk_part(input string tag, input int p, input logic [SW-1:0] s,
                          input logic [MW-1:0] x, input logic [MW-1:0] y);
    chk({tag, "_sad"}, bus.best_sad[p*SW +: SW], s);
    chk({tag, "_mvx"}, bus.best_mvx[p*MW +: MW], x);
    chk({tag, "_mvy"}, bus.best_mvy[p*MW +: MW], y);
  endtask

  // Feeds all 25 candidates; optionally a stall cycle before each one.
  // Returns in the DONE cycle.
  task automatic run_search(input int t, input bit toggle, input bit do_start);
    if (do_start) begin
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("start_busy", bus.busy, 1);
    end
    for (int c = 0; c < NC; c++) begin
      if (toggle) begin
        bus.sad_valid = 1'b0;
        bus.sad_in = '0;
        step();
        chk("stall_no_done", bus.done, 0);
      end
      bus.sad_valid = 1'b1;
      drive(t, c);
      step();
    end
    bus.sad_valid = 1'b0;
    chk("done_pulse", bus.done, 1);
    chk("done_not_busy", bus.busy, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.sad_valid = 1'b0;
    bus.sad_in = '0;

    // Reset state
    repeat (3) step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sad", bus.best_sad, {NP{16'hFFFF}});
    chk("rst_mvx", bus.best_mvx, '0);
    chk("rst_mvy", bus.best_mvy, '0);
    rst = 1'b1;
    step();

    // Test 1: reset asserted mid-search after 10 samples
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.sad_valid = 1'b1;
      drive(6, c);
      step();
    end
    bus.sad_valid = 1'b0;
    chk("t1_partial_sad", bus.best_sad[0 +: SW], 16'd291);
    #2 rst = 1'b0;
    #1;
    chk("t1_rst_busy", bus.busy, 0);
    chk("t1_rst_done", bus.done, 0);
    chk("t1_rst_sad", bus.best_sad, {NP{16'hFFFF}});
    chk("t1_rst_mvx", bus.best_mvx, '0);
    chk("t1_rst_mvy", bus.best_mvy, '0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Test 2: single minimum at candidate 12 (mv 0,0)
    run_search(2, 1'b0, 1'b1);
    chk("t2_sad", bus.best_sad, {NP{16'd5}});
    chk("t2_mvx", bus.best_mvx, '0);
    chk("t2_mvy", bus.best_mvy, '0);
    step();
    chk("t2_idle_done", bus.done, 0);
    chk("t2_idle_busy", bus.busy, 0);
    chk("t2_hold_sad", bus.best_sad, {NP{16'd5}});

    // Test 3: independent minima and sign handling
    run_search(3, 1'b0, 1'b1);
    chk_part("t3_p0", 0, 16'd3, 8'hFE, 8'hFE);
    chk_part("t3_p40", 40, 16'd7, 8'h02, 8'h02);
    chk_part("t3_p20", 20, 16'd500, 8'hFE, 8'hFE);
    step();

    // Test 4: tie keeps first occurrence
    run_search(4, 1'b0, 1'b1);
    chk_part("t4_p36", 36, 16'd50, 8'h02, 8'hFE);
    chk_part("t4_p5", 5, 16'd876, 8'h02, 8'h02);
    chk_part("t4_p0", 0, 16'd900, 8'hFE, 8'hFE);
    step();

    // Test 5: sad_valid toggling, zeros on stalled cycles
    run_search(5, 1'b1, 1'b1);
    chk_part("t5_p0", 0, 16'd128, 8'h02, 8'h02);
    chk_part("t5_p1", 1, 16'd100, 8'hFE, 8'hFE);
    chk_part("t5_p40", 40, 16'd128, 8'h02, 8'h02);
    step();

    // Test 6a: abort after 8 samples, abort wins over sad_valid
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.sad_valid = 1'b1;
      drive(6, c);
      step();
    end
    bus.abort = 1'b1;
    bus.sad_valid = 1'b1;
    bus.sad_in = '0;
    step();
    bus.abort = 1'b0;
    chk("t6_abort_busy", bus.busy, 0);
    chk("t6_abort_done", bus.done, 0);
    chk_part("t6_abort_p0", 0, 16'd293, 8'h00, 8'hFF);
    step();
    chk("t6_idle_done", bus.done, 0);
    chk_part("t6_idle_p3", 3, 16'd293, 8'h00, 8'hFF);
    bus.sad_valid = 1'b0;

    // Test 6b: start in the DONE cycle re-arms with no idle cycle
    run_search(2, 1'b0, 1'b1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t6_b2b_busy", bus.busy, 1);
    chk("t6_b2b_sad", bus.best_sad, {NP{16'hFFFF}});
    chk("t6_b2b_mvx", bus.best_mvx, '0);
    chk("t6_b2b_mvy", bus.best_mvy, '0);
    run_search(3, 1'b0, 1'b0);
    chk_part("t6_b2b_p0", 0, 16'd3, 8'hFE, 8'hFE);
    chk_part("t6_b2b_p40", 40, 16'd7, 8'h02, 8'h02);
    step();
    chk("t6_end_done", bus.done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
